de3d_tc_fill_sched: RTL and testbench

//  Texture-cache miss/fill scheduler that sits behind the tag-read address stage.

---
 rtl/de3d_tc_fill_sched_if.sv | 48 ++++
 rtl/de3d_tc_fill_sched.sv | 111 +++++++++++
 tb/tb_de3d_tc_fill_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/de3d_tc_fill_sched_if.sv
// Handshake bundle for the texture-cache fill scheduler.
// Lookup in, fill request/data, tag write, lookup done.
interface de3d_tc_fill_sched_if;
  logic       lookup_vld;
  logic [3:0] miss;
  logic [4:0] ee_tag_adr;
  logic [4:0] eo_tag_adr;
  logic [4:0] oe_tag_adr;
  logic [4:0] oo_tag_adr;
  logic [3:0] lookup_mipmap;
  logic       tc_stall;
  logic       fill_req;
  logic       fill_ack;
  logic [1:0] fill_bank;
  logic [4:0] fill_tag;
  logic [3:0] fill_mipmap;
  logic       fill_dvld;
  logic       tag_wr;
  logic [1:0] tag_wr_bank;
  logic [4:0] tag_wr_adr;
  logic       lookup_done;

  modport master (
    output lookup_vld, miss,
    output ee_tag_adr, eo_tag_adr,
    output oe_tag_adr, oo_tag_adr,
    output lookup_mipmap,
    output fill_ack, fill_dvld,
    input  tc_stall, fill_req,
    input  fill_bank, fill_tag,
    input  fill_mipmap, tag_wr,
    input  tag_wr_bank, tag_wr_adr,
    input  lookup_done
  );

  modport slave (
    input  lookup_vld, miss,
    input  ee_tag_adr, eo_tag_adr,
    input  oe_tag_adr, oo_tag_adr,
    input  lookup_mipmap,
    input  fill_ack, fill_dvld,
    output tc_stall, fill_req,
    output fill_bank, fill_tag,
    output fill_mipmap, tag_wr,
    output tag_wr_bank, tag_wr_adr,
    output lookup_done
  );
endinterface

// File: rtl/de3d_tc_fill_sched.sv
// Texture-cache miss/fill scheduler: stalls on a quad miss,
// fills each missing bank (ee>eo>oe>oo), writes tags, pulses done.
// Ports: de_clk, de_rst (sync, active high), bus (slave view).
module de3d_tc_fill_sched #(
  parameter int BURST_LEN = 4
) (
  input  logic de_clk,
  input  logic de_rst,
  de3d_tc_fill_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, DATA, UPD, DONE
  } state_t;

  state_t          state;
  logic [3:0]      pending;
  logic [4:0]      cnt;
  logic [3:0][4:0] tags;
  logic [3:0][4:0] in_tags;
  logic [3:0]      pend_clr;
  logic            capture;

  function automatic logic [1:0] first(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = 2'd3;
    priority case (1'b1)
      m[0]:    r = 2'd0;
      m[1]:    r = 2'd1;
      m[2]:    r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  assign in_tags = {bus.oo_tag_adr, bus.oe_tag_adr,
                    bus.eo_tag_adr, bus.ee_tag_adr};
  assign capture = (state == IDLE) & bus.lookup_vld
                 & (|bus.miss);
  // Stall in the capture cycle too, so the quad is held.
  assign bus.tc_stall = (state != IDLE) | capture;
  assign pend_clr = pending & ~(4'b0001 << bus.fill_bank);

  always_ff @(posedge de_clk) begin
    if (de_rst) begin
      state           <= IDLE;
      pending         <= '0;
      cnt             <= '0;
      tags            <= '0;
      bus.fill_req    <= 1'b0;
      bus.fill_bank   <= '0;
      bus.fill_tag    <= '0;
      bus.fill_mipmap <= '0;
      bus.tag_wr      <= 1'b0;
      bus.tag_wr_bank <= '0;
      bus.tag_wr_adr  <= '0;
      bus.lookup_done <= 1'b0;
    end else begin
      bus.tag_wr      <= 1'b0;
      bus.lookup_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            pending         <= bus.miss;
            tags            <= in_tags;
            bus.fill_req    <= 1'b1;
            bus.fill_bank   <= first(bus.miss);
            bus.fill_tag    <= in_tags[first(bus.miss)];
            bus.fill_mipmap <= bus.lookup_mipmap;
            state           <= REQ;
          end
        end
        REQ: begin
          if (bus.fill_ack) begin
            bus.fill_req <= 1'b0;
            cnt          <= '0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (bus.fill_dvld) begin
            cnt <= cnt + 5'd1;
            if (cnt + 5'd1 == 5'(BURST_LEN)) begin
              bus.tag_wr      <= 1'b1;
              bus.tag_wr_bank <= bus.fill_bank;
              bus.tag_wr_adr  <= bus.fill_tag;
              state           <= UPD;
            end
          end
        end
        UPD: begin
          pending <= pend_clr;
          if (|pend_clr) begin
            bus.fill_req  <= 1'b1;
            bus.fill_bank <= first(pend_clr);
            bus.fill_tag  <= tags[first(pend_clr)];
            state         <= REQ;
          end else begin
            bus.lookup_done <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de3d_tc_fill_sched.sv
// Self-checking bench for de3d_tc_fill_sched: vector table,
// fill/tag scoreboard, reset and BURST_LEN=1 sequences.
module tb_de3d_tc_fill_sched;

  localparam int BL = 4;

  logic de_clk = 1'b0;
  logic de_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 de_clk = ~de_clk;

  de3d_tc_fill_sched_if ifa ();
  de3d_tc_fill_sched_if ifb ();

  de3d_tc_fill_sched #(.BURST_LEN(BL)) dut_a (
    .de_clk (de_clk),
    .de_rst (de_rst),
    .bus    (ifa)
  );

  de3d_tc_fill_sched #(.BURST_LEN(1)) dut_b (
    .de_clk (de_clk),
    .de_rst (de_rst),
    .bus    (ifb)
  );

  typedef struct {
    logic [1:0] bank;
    logic [4:0] tag;
    logic [3:0] mip;
  } fill_t;

  typedef struct {
    logic [3:0] miss;
    logic [4:0] ee, eo, oe, oo;
    logic [3:0] mip;
    int         d;
    int         g;
    bit         stray;
    int         lat;
    int         wr1;
  } vec_t;

  fill_t qa[$];
  fill_t qb[$];
  vec_t  vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mon(input string nm, inout fill_t q[$],
                     input logic req, input logic ack,
                     input logic [1:0] fb, input logic [4:0] ft,
                     input logic [3:0] fm, input logic wr,
                     input logic [1:0] wb, input logic [4:0] wa);
    fill_t e;
    if (req && ack) begin
      if (q.size() == 0) chk({nm, "_fill_unexp"}, 1, 0);
      else chk({nm, "_fill"}, {fb, ft, fm},
               {q[0].bank, q[0].tag, q[0].mip});
    end
    if (wr) begin
      if (q.size() == 0) chk({nm, "_wr_unexp"}, 1, 0);
      else begin
        e = q.pop_front();
        chk({nm, "_tag_wr"}, {wb, wa}, {e.bank, e.tag});
      end
    end
  endtask

  always @(negedge de_clk) begin
    if (!de_rst) begin
      mon("a", qa, ifa.fill_req, ifa.fill_ack, ifa.fill_bank,
          ifa.fill_tag, ifa.fill_mipmap, ifa.tag_wr,
          ifa.tag_wr_bank, ifa.tag_wr_adr);
      mon("b", qb, ifb.fill_req, ifb.fill_ack, ifb.fill_bank,
          ifb.fill_tag, ifb.fill_mipmap, ifb.tag_wr,
          ifb.tag_wr_bank, ifb.tag_wr_adr);
    end
  end

  task automatic push_exp(input vec_t v, inout fill_t q[$]);
    logic [3:0][4:0] t;
    fill_t f;
    t = {v.oo, v.oe, v.eo, v.ee};
    for (int b = 0; b < 4; b++) begin
      if (v.miss[b]) begin
        f.bank = 2'(b);
        f.tag  = t[b];
        f.mip  = v.mip;
        q.push_back(f);
      end
    end
  endtask

  task automatic drive_a(input vec_t v);
    ifa.lookup_vld    = 1'b1;
    ifa.miss          = v.miss;
    ifa.ee_tag_adr    = v.ee;
    ifa.eo_tag_adr    = v.eo;
    ifa.oe_tag_adr    = v.oe;
    ifa.oo_tag_adr    = v.oo;
    ifa.lookup_mipmap = v.mip;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, wt, left, gc, nwr, wr1, lat, bad;
    n = $countones(v.miss);
    push_exp(v, qa);
    drive_a(v);
    @(negedge de_clk);
    chk($sformatf("v%0d_stall_cap", idx), 32'(ifa.tc_stall),
        32'(n != 0));
    @(posedge de_clk); #1;
    ifa.lookup_vld = 1'b0;
    ifa.miss       = '0;
    bad = 0;
    if (n == 0) begin
      repeat (4) begin
        @(negedge de_clk);
        if (ifa.fill_req || ifa.tc_stall) bad++;
      end
      chk($sformatf("v%0d_hit_idle", idx), 32'(bad), 0);
      @(posedge de_clk); #1;
      return;
    end
    wt = v.d; left = 0; gc = 0;
    nwr = 0; wr1 = -1; lat = -1;
    for (int cyc = 1; cyc <= 200 && lat < 0; cyc++) begin
      if (ifa.fill_req) begin
        ifa.fill_dvld = v.stray;
        if (wt == 0) begin
          ifa.fill_ack = 1'b1;
          wt = v.d; left = BL; gc = 0;
        end else begin
          ifa.fill_ack = 1'b0;
          wt--;
        end
      end else begin
        ifa.fill_ack = 1'b0;
        if (left > 0 && gc == 0) begin
          ifa.fill_dvld = 1'b1;
          left--;
          gc = v.g;
        end else begin
          ifa.fill_dvld = 1'b0;
          if (gc > 0) gc--;
        end
      end
      @(negedge de_clk);
      if (!ifa.tc_stall) bad++;
      if (ifa.tag_wr && ifa.lookup_done) bad++;
      if (ifa.tag_wr) begin
        nwr++;
        if (wr1 < 0) wr1 = cyc;
      end
      if (ifa.lookup_done) lat = cyc;
      @(posedge de_clk); #1;
    end
    ifa.fill_ack  = 1'b0;
    ifa.fill_dvld = 1'b0;
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_wr_count", idx), 32'(nwr), 32'(n));
    chk($sformatf("v%0d_first_wr", idx), 32'(wr1), 32'(v.wr1));
    chk($sformatf("v%0d_stall_hold", idx), 32'(bad), 0);
    @(negedge de_clk);
    chk($sformatf("v%0d_post_done", idx),
        {ifa.tc_stall, ifa.lookup_done, ifa.fill_req}, 0);
    @(posedge de_clk); #1;
  endtask

  initial begin
    int lat, bad;
    vec_t v;
    vt[0] = '{4'h0, 5'h01, 5'h02, 5'h03, 5'h04, 4'h1, 0, 0, 0, 0, -1};
    vt[1] = '{4'h4, 5'h00, 5'h00, 5'h13, 5'h00, 4'h3, 0, 0, 0, 7, 6};
    vt[2] = '{4'hF, 5'h01, 5'h02, 5'h03, 5'h04, 4'h5, 3, 0, 0, 37, 9};
    vt[3] = '{4'h1, 5'h1F, 5'h00, 5'h00, 5'h00, 4'h9, 2, 1, 1, 12, 11};
    vt[4] = '{4'h3, 5'h0C, 5'h15, 5'h00, 5'h00, 4'h7, 1, 0, 0, 15, 7};
    vt[5] = '{4'h8, 5'h00, 5'h00, 5'h00, 5'h0A, 4'hF, 0, 2, 0, 13, 12};

    ifa.lookup_vld = 0; ifa.miss = 0; ifa.lookup_mipmap = 0;
    ifa.ee_tag_adr = 0; ifa.eo_tag_adr = 0;
    ifa.oe_tag_adr = 0; ifa.oo_tag_adr = 0;
    ifa.fill_ack = 0; ifa.fill_dvld = 0;
    ifb.lookup_vld = 0; ifb.miss = 0; ifb.lookup_mipmap = 0;
    ifb.ee_tag_adr = 0; ifb.eo_tag_adr = 0;
    ifb.oe_tag_adr = 0; ifb.oo_tag_adr = 0;
    ifb.fill_ack = 0; ifb.fill_dvld = 0;

    repeat (3) @(posedge de_clk);
    #1 de_rst = 1'b0;
    @(negedge de_clk);
    chk("reset_outputs",
        {ifa.tc_stall, ifa.fill_req, ifa.tag_wr, ifa.lookup_done,
         ifa.fill_bank, ifa.fill_tag, ifa.fill_mipmap}, 0);
    @(posedge de_clk); #1;

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    // Reset in the middle of a DATA burst.
    v = vt[1];
    v.miss = 4'h2; v.eo = 5'h07;
    push_exp(v, qa);
    drive_a(v);
    @(posedge de_clk); #1;
    ifa.lookup_vld = 0; ifa.miss = 0;
    ifa.fill_ack = 1;
    @(posedge de_clk); #1;
    ifa.fill_ack = 0; ifa.fill_dvld = 1;
    repeat (2) @(posedge de_clk);
    #1 de_rst = 1'b1;
    bad = 0;
    @(posedge de_clk);
    @(negedge de_clk);
    chk("rst_mid_outputs",
        {ifa.tc_stall, ifa.fill_req, ifa.tag_wr, ifa.lookup_done,
         ifa.fill_bank, ifa.fill_tag}, 0);
    @(posedge de_clk); #1;
    de_rst = 1'b0;
    qa.delete();
    repeat (6) begin
      @(negedge de_clk);
      if (ifa.tag_wr || ifa.tc_stall || ifa.fill_req) bad++;
    end
    chk("rst_no_partial_wr", 32'(bad), 0);
    @(posedge de_clk); #1;
    ifa.fill_dvld = 0;

    // BURST_LEN=1 instance with ack/beats always available.
    v = vt[0];
    v.miss = 4'h9; v.ee = 5'h05; v.oo = 5'h1C; v.mip = 4'h2;
    push_exp(v, qb);
    ifb.lookup_vld = 1; ifb.miss = v.miss;
    ifb.ee_tag_adr = v.ee; ifb.oo_tag_adr = v.oo;
    ifb.lookup_mipmap = v.mip;
    ifb.fill_ack = 1; ifb.fill_dvld = 1;
    @(posedge de_clk); #1;
    ifb.lookup_vld = 0; ifb.miss = 0;
    lat = -1;
    for (int cyc = 1; cyc <= 30 && lat < 0; cyc++) begin
      @(negedge de_clk);
      if (ifb.lookup_done) lat = cyc;
      @(posedge de_clk); #1;
    end
    ifb.fill_ack = 0; ifb.fill_dvld = 0;
    chk("bl1_latency", 32'(lat), 7);
    repeat (2) @(posedge de_clk);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
